// File: rtl/logical_unit_pipe.sv
// logical_unit_pipe: single-issue logic/rotate unit with a valid/ready handshake.
// Bitwise ops finish in one cycle. Rotates step one bit per cycle through the
// ROT state. The result and its zero/parity flags sit in registers until the
// consumer takes them.

package opcodes;
  localparam int unsigned OP_AND  = 0;
  localparam int unsigned OP_OR   = 1;
  localparam int unsigned OP_XOR  = 2;
  localparam int unsigned OP_NOT  = 3;
  localparam int unsigned OP_NAND = 4;
  localparam int unsigned OP_NOR  = 5;
  localparam int unsigned OP_XNOR = 6;
  localparam int unsigned OP_ROL  = 7;
  localparam int unsigned OP_ROR  = 8;
endpackage

module logical_unit_pipe
  import opcodes::*;
#(
  parameter int WORD_SIZE   = 19,
  parameter int OPCODE_SIZE = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPCODE_SIZE-1:0] opcode,
  input  logic [WORD_SIZE-1:0]   operand_1,
  input  logic [WORD_SIZE-1:0]   operand_2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_SIZE-1:0]   out,
  output logic                   zero,
  output logic                   parity
);

  localparam int CW = (WORD_SIZE > 2) ? $clog2(WORD_SIZE) : 1;

  typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] out_q, out_d;
  logic [WORD_SIZE-1:0] work_q, work_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 left_q, left_d;
  logic                 zero_q, zero_d;
  logic                 parity_q, parity_d;

  logic                 accept;
  logic                 is_rol, is_ror;
  logic [CW-1:0]        rot_cnt;
  logic [WORD_SIZE-1:0] bw_res;
  logic [WORD_SIZE-1:0] rot_step;

  // Decode the incoming request: bitwise result, rotate kind and reduced count
  always_comb begin
    is_rol  = (opcode == OPCODE_SIZE'(OP_ROL));
    is_ror  = (opcode == OPCODE_SIZE'(OP_ROR));
    // Constant divisor, so this reduces to fixed logic.
    rot_cnt = CW'(operand_2 % WORD_SIZE'(WORD_SIZE));
    bw_res  = '0;
    case (opcode)
      OPCODE_SIZE'(OP_AND):  bw_res = operand_1 & operand_2;
      OPCODE_SIZE'(OP_OR):   bw_res = operand_1 | operand_2;
      OPCODE_SIZE'(OP_XOR):  bw_res = operand_1 ^ operand_2;
      OPCODE_SIZE'(OP_NOT):  bw_res = ~operand_1;
      OPCODE_SIZE'(OP_NAND): bw_res = ~(operand_1 & operand_2);
      OPCODE_SIZE'(OP_NOR):  bw_res = ~(operand_1 | operand_2);
      OPCODE_SIZE'(OP_XNOR): bw_res = ~(operand_1 ^ operand_2);
      default:               bw_res = '0;
    endcase
  end

  // One-bit rotate of the working register in the captured direction
  always_comb begin
    if (left_q) rot_step = {work_q[WORD_SIZE-2:0], work_q[WORD_SIZE-1]};
    else        rot_step = {work_q[0], work_q[WORD_SIZE-1:1]};
  end

  // Next-state, handshake outputs and result/flag next values
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    // Reset holds in_ready low even though the state reads IDLE.
    in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    out_valid = (state_q == DONE);
    accept    = in_valid && in_ready;

    case (state_q)
      IDLE: ;
      ROT: begin
        work_d = rot_step;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_d   = rot_step;
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new request overrides the above; from DONE this gives a bubble-free hand-off.
    if (accept) begin
      if ((is_rol || is_ror) && (rot_cnt != '0)) begin
        work_d  = operand_1;
        cnt_d   = rot_cnt;
        left_d  = is_rol;
        state_d = ROT;
      end else if (is_rol || is_ror) begin
        out_d   = operand_1;
        cnt_d   = '0;
        state_d = DONE;
      end else begin
        out_d   = bw_res;
        state_d = DONE;
      end
    end

    // Flags follow the registered result, never the live inputs.
    zero_d   = ~|out_d;
    parity_d = ^out_d;
  end

  // State, result and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      out_q    <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      zero_q   <= 1'b1;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      zero_q   <= zero_d;
      parity_q <= parity_d;
    end
  end

  assign out    = out_q;
  assign zero   = zero_q;
  assign parity = parity_q;

endmodule

// File: doc/logical_unit_pipe.md
LOGICAL_UNIT_PIPE -- requirements
Module: logical_unit_pipe

Interface
REQ-001 Parameter WORD_SIZE, default 19, operand/result width in bits (legal range 2..64).
REQ-002 Parameter OPCODE_SIZE, default 5, opcode width; opcode encodings SHALL come from the opcodes package.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 opcode  input  OPCODE_SIZE  operation select: AND, OR, XOR, NOT, NAND, NOR, XNOR, ROL, ROR.
REQ-008 operand_1  input  WORD_SIZE  first operand / rotate source.
REQ-009 operand_2  input  WORD_SIZE  second operand / rotate amount.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out  output  WORD_SIZE  registered result.
REQ-013 zero  output  1  registered flag, high when out is all zeros.
REQ-014 parity  output  1  registered flag, XOR-reduction of out.

Function
REQ-015 Request SHALL be accepted only on a cycle with in_valid && in_ready; opcode and operands SHALL be captured at acceptance and inputs ignored otherwise.
REQ-016 FSM states SHALL be IDLE, ROT, DONE.
REQ-017 IDLE: in_ready=1, out_valid=0; on acceptance of a bitwise op go to DONE; of ROL/ROR with count>0 go to ROT; with count=0 go to DONE holding operand_1.
REQ-018 Bitwise ops SHALL produce: AND a&b, OR a|b, XOR a^b, NOT ~a, NAND ~(a&b), NOR ~(a|b), XNOR ~(a^b); any other opcode SHALL produce 0 (NOP).
REQ-019 Rotate count SHALL be operand_2 mod WORD_SIZE, computed at acceptance.
REQ-020 ROT: working register rotates by exactly one bit per cycle (ROL toward MSB, MSB into bit 0; ROR toward LSB, bit 0 into MSB); count decrements; at count reaching 0, go to DONE; in_ready=0, out_valid=0.
REQ-021 Latency: bitwise op or zero-count rotate SHALL assert out_valid on the cycle after acceptance; rotate by k>0 SHALL assert out_valid k+1 cycles after acceptance.
REQ-022 DONE: out_valid=1; out, zero, parity SHALL be stable until out_valid && out_ready.
REQ-023 DONE with out_ready=0: in_ready=0, state held indefinitely.
REQ-024 DONE with out_ready=1: in_ready=1; simultaneous acceptance SHALL start the new request (next state per REQ-017) with no bubble; without acceptance return to IDLE.
REQ-025 Back-to-back bitwise requests with out_ready held high SHALL sustain one result per cycle.
REQ-026 zero and parity SHALL be updated in the same cycle as out, never combinationally from inputs.

Reset
REQ-027 While rst is high: state=IDLE, out=0, zero=1, parity=0, out_valid=0, in_ready=0, rotate count=0.
REQ-028 Reset asserted mid-ROT or in DONE SHALL discard the operation with no result emitted after release.
REQ-029 First cycle after rst deasserts: in_ready=1.

Verification
REQ-030 AND, operand_1=0x7FFFF, operand_2=0x0F0F0, out_ready=1 -> next cycle out_valid=1, out=0x0F0F0, zero=0, parity=0.
REQ-031 XNOR, operand_1=operand_2=0x12345 -> out=0x7FFFF, parity=1; NOR 0x7FFFF,0 -> out=0, zero=1; undefined opcode -> out=0.
REQ-032 ROL, operand_1=0x00001, operand_2=3 -> out_valid 4 cycles after acceptance, out=0x00008; ROR 0x00001 by 1 -> out=0x40000 after 2 cycles; ROL by 19 or 0 -> out=operand_1 after 1 cycle; ROL by 20 -> same as by 1.
REQ-033 out_ready=0 for 5 cycles in DONE -> out/flags unchanged, in_ready=0, in_valid requests not accepted; out_ready rises with in_valid -> new request accepted same cycle.
REQ-034 Stream of 8 bitwise requests, in_valid and out_ready held high -> 8 results on 8 consecutive cycles in issue order.
REQ-035 rst pulsed during ROT (ROL by 10, cycle 4) -> all outputs at reset values, no out_valid afterwards until a new request.
